// File: rtl/frac_clken_gen.sv
// frac_clken_gen
// Multi-channel fractional clock-enable generator. Each channel runs its own
// phase accumulator clocked by refclk. The accumulator carry-out gives a
// single-cycle enable pulse and its MSB gives a square-wave clock, so each
// output runs at f_refclk * incr / 2^ACC_W. A small control FSM holds the
// outputs low until the accumulators have run for LOCK_CYCLES cycles, and
// then raises locked.
//
// Ports
//   refclk     sole clock, all state changes on its rising edge
//   rst        synchronous active-high reset
//   enable     1 = generate, 0 = halt (accumulators hold)
//   cfg_valid  configuration write request
//   cfg_ready  write can be accepted (low for one cycle after each accept)
//   cfg_ch     target channel; indices >= NUM_CH are acknowledged and dropped
//   cfg_incr   frequency word for the target channel
//   cfg_phase  phase offset / accumulator preload for the target channel
//   clken      per-channel single-cycle enable pulses
//   clkout     per-channel square-wave outputs
//   locked     outputs are valid and stable
module frac_clken_gen #(
  parameter int NUM_CH      = 3,
  parameter int ACC_W       = 32,
  parameter int LOCK_CYCLES = 16,
  parameter int CH_W        = (NUM_CH > 1) ? $clog2(NUM_CH) : 1
) (
  input  logic              refclk,
  input  logic              rst,
  input  logic              enable,
  input  logic              cfg_valid,
  output logic              cfg_ready,
  input  logic [CH_W-1:0]   cfg_ch,
  input  logic [ACC_W-1:0]  cfg_incr,
  input  logic [ACC_W-1:0]  cfg_phase,
  output logic [NUM_CH-1:0] clken,
  output logic [NUM_CH-1:0] clkout,
  output logic              locked
);

  localparam int CNT_W = (LOCK_CYCLES > 1) ? $clog2(LOCK_CYCLES) : 1;
  localparam logic [CNT_W-1:0] CNT_RELOAD = CNT_W'(LOCK_CYCLES - 1);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    SETTLE = 2'd1,
    LOCKED = 2'd2
  } state_t;

  state_t             state_q, state_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic               locked_q;
  logic               cfgReady_q, cfgReady_d;

  logic [ACC_W-1:0]   incr_q  [NUM_CH];
  logic [ACC_W-1:0]   incr_d  [NUM_CH];
  logic [ACC_W-1:0]   phase_q [NUM_CH];
  logic [ACC_W-1:0]   phase_d [NUM_CH];
  logic [ACC_W-1:0]   acc_q   [NUM_CH];
  logic [ACC_W-1:0]   acc_d   [NUM_CH];
  logic [ACC_W:0]     sum     [NUM_CH];

  logic [NUM_CH-1:0]  clken_q, clken_d;
  logic [NUM_CH-1:0]  clkout_q, clkout_d;

  logic               wrAccept;
  logic               wrHit;

  // A write handshake always completes; only in-range channels act on it.
  assign wrAccept = cfg_valid & cfgReady_q;
  assign wrHit    = wrAccept & (int'(cfg_ch) < NUM_CH);

  // Extra top bit of each sum is the accumulator carry-out.
  for (genvar g = 0; g < NUM_CH; g++) begin : g_sum
    assign sum[g] = {1'b0, acc_q[g]} + {1'b0, incr_q[g]};
  end

  // Next state: enable low always wins; a real write restarts settling.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    if (!enable) begin
      state_d = IDLE;
    end else begin
      unique case (state_q)
        IDLE: begin
          state_d = SETTLE;
          cnt_d   = CNT_RELOAD;
        end
        SETTLE: begin
          if (wrHit) begin
            cnt_d = CNT_RELOAD;
          end else if (cnt_q == '0) begin
            state_d = LOCKED;
          end else begin
            cnt_d = cnt_q - CNT_W'(1);
          end
        end
        LOCKED: begin
          if (wrHit) begin
            state_d = SETTLE;
            cnt_d   = CNT_RELOAD;
          end
        end
        default: begin
          state_d = IDLE;
        end
      endcase
    end
  end

  // Control FSM with registered locked flag.
  always_ff @(posedge refclk) begin
    if (rst) begin
      state_q  <= IDLE;
      cnt_q    <= '0;
      locked_q <= 1'b0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      locked_q <= (state_d == LOCKED);
    end
  end

  // Per-channel datapath. Leaving IDLE reloads every accumulator from its
  // phase; a write to a channel overrides that channel's accumulator with
  // the new phase. Outputs are only passed through when heading to LOCKED,
  // which also guarantees a freshly written channel emits nothing that cycle.
  always_comb begin
    cfgReady_d = ~wrAccept;
    for (int i = 0; i < NUM_CH; i++) begin
      incr_d[i]   = incr_q[i];
      phase_d[i]  = phase_q[i];
      acc_d[i]    = acc_q[i];
      clken_d[i]  = 1'b0;
      clkout_d[i] = 1'b0;
      if (state_q != IDLE) begin
        acc_d[i] = sum[i][ACC_W-1:0];
      end else if (enable) begin
        acc_d[i] = phase_q[i];
      end
      if (wrHit && (int'(cfg_ch) == i)) begin
        incr_d[i]  = cfg_incr;
        phase_d[i] = cfg_phase;
        acc_d[i]   = cfg_phase;
      end
      if (state_d == LOCKED) begin
        clken_d[i]  = sum[i][ACC_W];
        clkout_d[i] = acc_d[i][ACC_W-1];
      end
    end
  end

  // Datapath registers; reset discards any write presented alongside it.
  always_ff @(posedge refclk) begin
    if (rst) begin
      for (int i = 0; i < NUM_CH; i++) begin
        incr_q[i]  <= '0;
        phase_q[i] <= '0;
        acc_q[i]   <= '0;
      end
      clken_q    <= '0;
      clkout_q   <= '0;
      cfgReady_q <= 1'b0;
    end else begin
      for (int i = 0; i < NUM_CH; i++) begin
        incr_q[i]  <= incr_d[i];
        phase_q[i] <= phase_d[i];
        acc_q[i]   <= acc_d[i];
      end
      clken_q    <= clken_d;
      clkout_q   <= clkout_d;
      cfgReady_q <= cfgReady_d;
    end
  end

  assign clken     = clken_q;
  assign clkout    = clkout_q;
  assign locked    = locked_q;
  assign cfg_ready = cfgReady_q;

endmodule

// File: tb/tb_frac_clken_gen.sv
// tb_frac_clken_gen
// Directed testbench for frac_clken_gen with NUM_CH=3, ACC_W=8,
// LOCK_CYCLES=4. Expected pulse/level patterns are hand-derived from the
// chosen frequency words and phases.
module tb_frac_clken_gen;

  localparam int NUM_CH      = 3;
  localparam int ACC_W       = 8;
  localparam int LOCK_CYCLES = 4;
  localparam int CH_W        = 2;

  logic              refclk = 1'b0;
  logic              rst;
  logic              enable;
  logic              cfg_valid;
  logic              cfg_ready;
  logic [CH_W-1:0]   cfg_ch;
  logic [ACC_W-1:0]  cfg_incr;
  logic [ACC_W-1:0]  cfg_phase;
  logic [NUM_CH-1:0] clken;
  logic [NUM_CH-1:0] clkout;
  logic              locked;

  int numChecks = 0;
  int numFails  = 0;

  frac_clken_gen #(
    .NUM_CH      (NUM_CH),
    .ACC_W       (ACC_W),
    .LOCK_CYCLES (LOCK_CYCLES),
    .CH_W        (CH_W)
  ) dut (
    .refclk    (refclk),
    .rst       (rst),
    .enable    (enable),
    .cfg_valid (cfg_valid),
    .cfg_ready (cfg_ready),
    .cfg_ch    (cfg_ch),
    .cfg_incr  (cfg_incr),
    .cfg_phase (cfg_phase),
    .clken     (clken),
    .clkout    (clkout),
    .locked    (locked)
  );

  // Free-running reference clock, 10 time units per period.
  always #5 refclk = ~refclk;

  // Single comparison point: counts every check and reports mismatches.
  task automatic checkOutput(input string tag, input logic [31:0] observed,
                             input logic [31:0] expected);
    numChecks++;
    if (observed !== expected) begin
      numFails++;
      $display("[TB] FAIL %s: observed 0x%0h, expected 0x%0h", tag, observed, expected);
    end
  endtask

  // Advance one edge and settle just past it before sampling or driving.
  task automatic step();
    @(posedge refclk);
    #1;
  endtask

  task automatic stepN(input int n);
    for (int i = 0; i < n; i++) step();
  endtask

  // One configuration write: valid is held for exactly one edge.
  task automatic applyStimulus(input logic [CH_W-1:0] ch, input logic [ACC_W-1:0] incr,
                               input logic [ACC_W-1:0] phase);
    cfg_ch    = ch;
    cfg_incr  = incr;
    cfg_phase = phase;
    cfg_valid = 1'b1;
    step();
    cfg_valid = 1'b0;
  endtask

  initial begin
    logic [NUM_CH-1:0] expEn;
    logic [NUM_CH-1:0] expOut;
    int pulses0;
    int pulses1;
    int pulses2;

    rst       = 1'b1;
    enable    = 1'b0;
    cfg_valid = 1'b0;
    cfg_ch    = '0;
    cfg_incr  = '0;
    cfg_phase = '0;

    // Reset state.
    stepN(3);
    checkOutput("reset locked", 32'(locked), 32'd0);
    checkOutput("reset clken", 32'(clken), 32'd0);
    checkOutput("reset clkout", 32'(clkout), 32'd0);
    checkOutput("reset cfg_ready", 32'(cfg_ready), 32'd0);
    rst = 1'b0;
    step();
    checkOutput("ready after reset", 32'(cfg_ready), 32'd1);
    checkOutput("idle locked", 32'(locked), 32'd0);

    // Single channel, quarter-rate frequency word.
    applyStimulus(2'd0, 8'h40, 8'h00);
    checkOutput("ready low after write", 32'(cfg_ready), 32'd0);
    step();
    checkOutput("ready back after write", 32'(cfg_ready), 32'd1);
    enable = 1'b1;
    step();
    checkOutput("settle E0 locked", 32'(locked), 32'd0);
    for (int k = 1; k < 4; k++) begin
      step();
      checkOutput("settle locked", 32'(locked), 32'd0);
    end
    step();
    for (int k = 0; k < 8; k++) begin
      if (k > 0) step();
      expEn  = {1'b0, 1'b0, (k % 4 == 0)};
      expOut = {1'b0, 1'b0, (k % 4 >= 2)};
      checkOutput("A locked", 32'(locked), 32'd1);
      checkOutput("A clken", 32'(clken), 32'(expEn));
      checkOutput("A clkout", 32'(clkout), 32'(expOut));
    end

    // Two channels half a cycle apart.
    enable = 1'b0;
    step();
    checkOutput("disable drops locked", 32'(locked), 32'd0);
    checkOutput("disable clken", 32'(clken), 32'd0);
    applyStimulus(2'd1, 8'h40, 8'h80);
    step();
    enable = 1'b1;
    stepN(4);
    checkOutput("B settle locked", 32'(locked), 32'd0);
    step();
    for (int k = 0; k < 8; k++) begin
      if (k > 0) step();
      expEn  = {1'b0, (k % 4 == 2), (k % 4 == 0)};
      expOut = {1'b0, (k % 4 < 2), (k % 4 >= 2)};
      checkOutput("B locked", 32'(locked), 32'd1);
      checkOutput("B clken", 32'(clken), 32'(expEn));
      checkOutput("B clkout", 32'(clkout), 32'(expOut));
    end

    // Write while locked: relock, and 3-in-16 pulse rate on ch2.
    applyStimulus(2'd2, 8'h30, 8'h00);
    checkOutput("C locked drops", 32'(locked), 32'd0);
    checkOutput("C ready low", 32'(cfg_ready), 32'd0);
    checkOutput("C clken forced", 32'(clken), 32'd0);
    step();
    checkOutput("C ready back", 32'(cfg_ready), 32'd1);
    checkOutput("C W1 locked", 32'(locked), 32'd0);
    stepN(2);
    checkOutput("C W3 locked", 32'(locked), 32'd0);
    step();
    checkOutput("C W4 locked", 32'(locked), 32'd1);
    checkOutput("C W4 clkout2", 32'(clkout[2]), 32'd1);
    checkOutput("C W4 clken2", 32'(clken[2]), 32'd0);
    pulses2 = int'(clken[2]);
    for (int k = 1; k < 16; k++) begin
      step();
      pulses2 += int'(clken[2]);
    end
    checkOutput("C ch2 pulses per 16", 32'(pulses2), 32'd3);

    // Out-of-range write: acknowledged, no relock, channels keep running.
    applyStimulus(2'd3, 8'h00, 8'h00);
    checkOutput("D locked kept", 32'(locked), 32'd1);
    checkOutput("D ready low", 32'(cfg_ready), 32'd0);
    pulses0 = int'(clken[0]);
    pulses1 = int'(clken[1]);
    pulses2 = int'(clken[2]);
    for (int k = 1; k < 16; k++) begin
      step();
      pulses0 += int'(clken[0]);
      pulses1 += int'(clken[1]);
      pulses2 += int'(clken[2]);
    end
    checkOutput("D ch0 pulses", 32'(pulses0), 32'd4);
    checkOutput("D ch1 pulses", 32'(pulses1), 32'd4);
    checkOutput("D ch2 pulses", 32'(pulses2), 32'd3);
    checkOutput("D locked end", 32'(locked), 32'd1);

    // Write in the same cycle enable falls: applied, state goes IDLE.
    cfg_ch    = 2'd2;
    cfg_incr  = 8'h80;
    cfg_phase = 8'h80;
    cfg_valid = 1'b1;
    enable    = 1'b0;
    step();
    cfg_valid = 1'b0;
    checkOutput("E locked", 32'(locked), 32'd0);
    checkOutput("E clken", 32'(clken), 32'd0);
    checkOutput("E clkout", 32'(clkout), 32'd0);
    checkOutput("E ready low", 32'(cfg_ready), 32'd0);
    step();
    checkOutput("E idle locked", 32'(locked), 32'd0);
    enable = 1'b1;
    stepN(4);
    checkOutput("E settle locked", 32'(locked), 32'd0);
    step();
    for (int k = 0; k < 4; k++) begin
      if (k > 0) step();
      expEn  = {(k % 2 == 1), (k % 4 == 2), (k % 4 == 0)};
      expOut = {(k % 2 == 0), (k % 4 < 2), (k % 4 >= 2)};
      checkOutput("E locked run", 32'(locked), 32'd1);
      checkOutput("E clken", 32'(clken), 32'(expEn));
      checkOutput("E clkout", 32'(clkout), 32'(expOut));
    end

    // Reset mid-LOCKED with a competing write and enable still high.
    rst       = 1'b1;
    cfg_ch    = 2'd0;
    cfg_incr  = 8'hFF;
    cfg_phase = 8'hFF;
    cfg_valid = 1'b1;
    step();
    checkOutput("R locked", 32'(locked), 32'd0);
    checkOutput("R clken", 32'(clken), 32'd0);
    checkOutput("R clkout", 32'(clkout), 32'd0);
    checkOutput("R ready", 32'(cfg_ready), 32'd0);
    step();
    rst       = 1'b0;
    cfg_valid = 1'b0;
    step();
    checkOutput("R ready after", 32'(cfg_ready), 32'd1);
    checkOutput("R locked after", 32'(locked), 32'd0);
    stepN(4);
    checkOutput("R relocked", 32'(locked), 32'd1);
    pulses0 = 0;
    for (int k = 0; k < 8; k++) begin
      if (k > 0) step();
      pulses0 += int'(clken[0]) + int'(clken[1]) + int'(clken[2]);
      checkOutput("R clkout idle", 32'(clkout), 32'd0);
    end
    checkOutput("R no pulses", 32'(pulses0), 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", numChecks, numFails);
    $finish;
  end

endmodule
